// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the memory-mapped UART: register offsets inside
// the 4-word window, STATUS bit positions, the state encoding used by both
// the TX and RX sequencers, and the divisor clamp helper.
// No ports; imported by uart_fifo and uart_mmio.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_IDLE    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // A bit period shorter than two clocks cannot be split into a
    // half-bit wait, so 0 and 1 behave like 2.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo
// Synchronous FIFO holding bytes waiting for the TX serializer.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_data       write request and data (dropped when full)
//   pop                   read request (ignored when empty)
//   pop_data              current head entry (valid while !empty)
//   full, empty           occupancy flags
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update. Fullness is taken from the registered pointers, so a
    // push arriving in the same cycle as a pop still sees the old state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio
// Memory-mapped UART on the shared cpu data bus. Four word registers at
// BASE..BASE+3: DATA (TX push / RX holding byte), STATUS, DIVISOR, unused.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   mem_re, mem_we  bus read / store strobes (one full cycle each)
//   memaddr         word address
//   memdata         shared bus data, driven only while reading this block
//   txd             serial output, idle high
//   rxd             asynchronous serial input
//   irq             rx_valid | rx_overrun | frame_err
module uart_mmio
    import uart_pkg::*;
#(
    parameter logic [29:0] BASE      = 30'h3FFFFF00,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [29:0] memaddr,
    inout  wire  [31:0] memdata,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);

    logic        sel;
    logic [1:0]  reg_idx;
    logic        bus_rd;
    logic        bus_wr;
    logic        data_read;
    logic [31:0] rdata;
    logic [15:0] div_reg;
    logic [15:0] div_eff;
    logic [15:0] div_half;
    logic        unused_wdata;

    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;
    logic        tx_pop;
    logic        tx_idle;

    uart_state_t rx_state, rx_next;
    logic        rxd_s1;
    logic        rxd_s2;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_tick;
    logic        rx_done_ok;
    logic        rx_done_bad;
    logic        rx_valid;
    logic        rx_overrun;
    logic        frame_err;
    logic [7:0]  rx_hold;

    assign sel       = (memaddr[29:2] == BASE[29:2]);
    assign reg_idx   = memaddr[1:0];
    assign bus_rd    = mem_re && sel;
    assign bus_wr    = mem_we && sel && !mem_re;
    assign data_read = bus_rd && (reg_idx == REG_DATA);
    assign fifo_push = bus_wr && (reg_idx == REG_DATA);
    assign div_eff   = eff_div(div_reg);
    assign div_half  = div_eff >> 1;
    assign tx_tick   = (tx_cnt == 16'd0);
    assign rx_tick   = (rx_cnt == 16'd0);
    assign tx_idle   = fifo_empty && (tx_state == S_IDLE);
    assign irq       = rx_valid | rx_overrun | frame_err;
    assign memdata   = bus_rd ? rdata : 'z;
    assign unused_wdata = ^memdata[31:16];

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (memdata[7:0]),
        .pop       (tx_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Register read mux; only reaches the bus while this block is selected.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_DATA:   rdata[7:0] = rx_hold;
            REG_STATUS: begin
                rdata[ST_TX_FULL]    = fifo_full;
                rdata[ST_TX_IDLE]    = tx_idle;
                rdata[ST_RX_VALID]   = rx_valid;
                rdata[ST_RX_OVERRUN] = rx_overrun;
                rdata[ST_FRAME_ERR]  = frame_err;
            end
            REG_DIV:    rdata[15:0] = div_reg;
            default:    rdata = '0;
        endcase
    end

    // Divisor register; the sequencers pick up a new value at their next
    // bit-counter reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg <= DIV_RESET;
        end else if (bus_wr && (reg_idx == REG_DIV)) begin
            div_reg <= memdata[15:0];
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // TX next state: one pop cycle in IDLE, then start, 8 data, stop.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (!fifo_empty) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = S_STOP;
            S_STOP:  if (tx_tick) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // TX outputs: line level and the FIFO pop taken while leaving IDLE.
    always_comb begin
        txd    = 1'b1;
        tx_pop = 1'b0;
        case (tx_state)
            S_IDLE:  tx_pop = !fifo_empty;
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_shift[0];
            S_STOP:  txd = 1'b1;
            default: txd = 1'b1;
        endcase
    end

    // TX bit timer and shifter. The counter holds the clocks remaining in
    // the current bit minus one, so each bit lasts exactly div_eff clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        tx_shift <= fifo_dout;
                        tx_cnt   <= div_eff - 16'd1;
                    end
                end
                S_START: begin
                    if (tx_tick) begin
                        tx_cnt <= div_eff - 16'd1;
                        tx_bit <= 3'd0;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt   <= div_eff - 16'd1;
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (!tx_tick) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_cnt <= '0;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous rxd pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // RX next state: a low that has vanished by mid start bit is a glitch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rxd_s2) rx_next = S_START;
            S_START: if (rx_tick) rx_next = rxd_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    // RX outputs: frame completion events at the mid-stop sample.
    always_comb begin
        rx_done_ok  = 1'b0;
        rx_done_bad = 1'b0;
        if ((rx_state == S_STOP) && rx_tick) begin
            rx_done_ok  = rxd_s2;
            rx_done_bad = !rxd_s2;
        end
    end

    // RX bit timer and shifter. The first wait is half a bit so every
    // later sample lands mid-bit; data arrives LSB first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rxd_s2) begin
                        rx_cnt <= div_half - 16'd1;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        rx_cnt <= div_eff - 16'd1;
                        rx_bit <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= div_eff - 16'd1;
                        rx_bit   <= rx_bit + 3'd1;
                        rx_shift <= {rxd_s2, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (!rx_tick) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    // Receive flags and holding byte. Clears come first so a same-cycle
    // error event wins; a DATA read that coincides with a new byte frees
    // the holding register, so the new byte loads without an overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_hold    <= '0;
        end else begin
            if (bus_wr && (reg_idx == REG_STATUS) && memdata[ST_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
            if (bus_wr && (reg_idx == REG_STATUS) && memdata[ST_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
            if (rx_done_bad) begin
                frame_err <= 1'b1;
            end
            if (rx_done_ok) begin
                if (!rx_valid || data_read) begin
                    rx_hold  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (data_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio
// Self-checking bench for uart_mmio: random bytes and divisors on both
// directions, checked against a frame-level model of the UART (expected
// byte queue for TX, flag/holding-byte model for RX).
module tb_uart_mmio;
    import uart_pkg::*;

    localparam logic [29:0] BASE     = 30'h3FFFFF00;
    localparam int          TX_DEPTH = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        mem_re   = 1'b0;
    logic        mem_we   = 1'b0;
    logic [29:0] memaddr  = '0;
    logic [31:0] tb_wdata = '0;
    logic        tb_drive = 1'b0;
    logic        rxd      = 1'b1;
    wire  [31:0] memdata;
    logic        txd;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // TX side: bytes the line decoder saw and bytes the model expects.
    logic [7:0] tx_got[$];
    logic [7:0] exp_tx[$];
    int         mon_div = 868;
    bit         mon_en  = 1'b1;

    // RX side model.
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic [7:0] m_hold  = 8'h00;

    assign memdata = tb_drive ? tb_wdata : 'z;

    always #5 clk = ~clk;

    uart_mmio #(.BASE(BASE), .TX_DEPTH(TX_DEPTH), .DIV_RESET(16'd868)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_re  (mem_re),
        .mem_we  (mem_we),
        .memaddr (memaddr),
        .memdata (memdata),
        .txd     (txd),
        .rxd     (rxd),
        .irq     (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bus helpers: entered and left on a falling clock edge.
    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        memaddr  = BASE + 30'(r);
        tb_wdata = d;
        tb_drive = 1'b1;
        mem_we   = 1'b1;
        @(negedge clk);
        mem_we   = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        memaddr = BASE + 30'(r);
        mem_re  = 1'b1;
        #1 d = memdata;
        @(negedge clk);
        mem_re = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        return {27'b0, m_ferr, m_ovr, m_valid, 1'b1, 1'b0};
    endfunction

    task automatic set_div(input logic [15:0] d);
        logic [31:0] rd;
        bus_write(REG_DIV, {16'hBEEF, d});
        mon_div = (d < 16'd2) ? 2 : int'(d);
        bus_read(REG_DIV, rd);
        checkOutput("div_readback", rd, {16'h0, d});
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        bus_read(REG_STATUS, s);
        while (!s[1] && n < 4000) begin
            bus_read(REG_STATUS, s);
            n++;
        end
        checkOutput(tag, 32'(s[1]), 32'd1);
    endtask

    task automatic compare_tx(input string tag);
        checkOutput({tag, "_count"}, 32'(tx_got.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
            checkOutput(tag, 32'(tx_got[i]), 32'(exp_tx[i]));
        end
        tx_got.delete();
        exp_tx.delete();
    endtask

    // Back-to-back stores from an idle transmitter: the serializer takes the
    // first byte one cycle after it lands, so TX_DEPTH+1 bytes fit before
    // further stores are dropped.
    task automatic applyStimulus(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (i < TX_DEPTH + 1) exp_tx.push_back(w[7:0]);
            bus_write(REG_DATA, w);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (d) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (d + 4) @(negedge clk);
        if (!stop) m_ferr = 1'b1;
        else if (!m_valid) begin
            m_hold  = b;
            m_valid = 1'b1;
        end else m_ovr = 1'b1;
    endtask

    task automatic check_rx_state(input string tag);
        logic [31:0] rd;
        bus_read(REG_STATUS, rd);
        checkOutput({tag, "_status"}, rd, exp_status());
        checkOutput({tag, "_irq"}, 32'(irq), 32'(m_valid | m_ovr | m_ferr));
    endtask

    // Line decoder: finds a start bit, then samples every bit at mid-bit.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       start_lvl;
        logic       stop_lvl;
        int         d;
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                d = mon_div;
                repeat (d / 2) @(negedge clk);
                start_lvl = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = txd;
                end
                repeat (d) @(negedge clk);
                stop_lvl = txd;
                if (mon_en) begin
                    checkOutput("tx_start_bit", 32'(start_lvl), 32'd0);
                    checkOutput("tx_stop_bit", 32'(stop_lvl), 32'd1);
                    tx_got.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [31:0] rd;
        logic [31:0] pat;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        samp[40];
        logic [9:0]  frame;
        logic        low_seen;
        int          d;
        int          k;

        // Reset and default register values.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_txd", 32'(txd), 32'd1);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        bus_read(REG_STATUS, rd);
        checkOutput("reset_status", rd, 32'h2);
        bus_read(REG_DIV, rd);
        checkOutput("reset_div", rd, 32'd868);
        bus_read(REG_DATA, rd);
        checkOutput("reset_rx_hold", rd, 32'h0);
        bus_write(2'd3, $urandom);
        bus_read(2'd3, rd);
        checkOutput("reg3_read", rd, 32'h0);
        bus_read(REG_DIV, rd);
        checkOutput("reg3_write_ignored", rd, 32'd868);

        // Bus released when idle and when another slave is addressed.
        pat = $urandom;
        memaddr  = BASE + 30'd1;
        tb_wdata = pat;
        tb_drive = 1'b1;
        #1 checkOutput("bus_release_idle", memdata, pat);
        memaddr = BASE + 30'd4;
        mem_re  = 1'b1;
        #1 checkOutput("bus_release_unselected", memdata, pat);
        @(negedge clk);
        mem_re   = 1'b0;
        tb_drive = 1'b0;

        // Directed 0xA5 frame, each level held exactly 4 clocks.
        set_div(16'd4);
        exp_tx.push_back(8'hA5);
        bus_write(REG_DATA, 32'h000000A5);
        k = 0;
        while (txd !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("a5_start_seen", 32'(txd), 32'd0);
        for (int i = 0; i < 40; i++) begin
            samp[i] = txd;
            @(negedge clk);
        end
        frame = {1'b1, 8'hA5, 1'b0};
        for (int bt = 0; bt < 10; bt++) begin
            checkOutput($sformatf("a5_bit%0d", bt),
                        {28'h0, samp[4*bt+3], samp[4*bt+2], samp[4*bt+1], samp[4*bt]},
                        {28'h0, {4{frame[bt]}}});
        end
        wait_tx_idle("a5_idle");
        bus_read(REG_STATUS, rd);
        checkOutput("a5_status_after", rd, 32'h2);
        compare_tx("a5_byte");

        // Seven rapid stores: five sent, the rest dropped, full observed.
        applyStimulus(7);
        bus_read(REG_STATUS, rd);
        checkOutput("burst7_full", 32'(rd[0]), 32'd1);
        wait_tx_idle("burst7_idle");
        compare_tx("burst7_byte");

        // Random divisors (including 0/1) and burst lengths.
        for (int r = 0; r < 6; r++) begin
            set_div(16'($urandom_range(0, 7)));
            applyStimulus($urandom_range(1, 7));
            wait_tx_idle("rand_tx_idle");
            compare_tx("rand_tx_byte");
        end

        // Directed receive of 0x3C.
        set_div(16'd4);
        send_rx(8'h3C, 1'b1, 4);
        bus_read(REG_STATUS, rd);
        checkOutput("rx3c_status", rd, 32'h6);
        checkOutput("rx3c_irq", 32'(irq), 32'd1);
        bus_read(REG_DATA, rd);
        checkOutput("rx3c_data", rd, 32'h3C);
        m_valid = 1'b0;
        bus_read(REG_STATUS, rd);
        checkOutput("rx3c_cleared", rd, 32'h2);

        // Two frames without a read: overrun, first byte kept.
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send_rx(b0, 1'b1, 4);
        send_rx(b1, 1'b1, 4);
        bus_read(REG_STATUS, rd);
        checkOutput("overrun_status", rd, 32'h0E);
        bus_write(REG_STATUS, 32'h8);
        m_ovr = 1'b0;
        bus_read(REG_STATUS, rd);
        checkOutput("overrun_cleared", rd, 32'h06);
        bus_read(REG_DATA, rd);
        checkOutput("overrun_hold", rd, {24'h0, b0});
        m_valid = 1'b0;

        // Bad stop bit.
        send_rx(8'($urandom), 1'b0, 4);
        check_rx_state("frame_err");
        bus_write(REG_STATUS, 32'h10);
        m_ferr = 1'b0;
        check_rx_state("frame_err_cleared");

        // One-clock low glitch must be rejected.
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (12) @(negedge clk);
        check_rx_state("glitch");
        bus_read(REG_DATA, rd);
        checkOutput("glitch_hold", rd, {24'h0, m_hold});

        // Random receive traffic with random reads and flag clears.
        for (int r = 0; r < 10; r++) begin
            d = $urandom_range(3, 8);
            set_div(16'(d));
            send_rx(8'($urandom), ($urandom_range(0, 5) != 0), d);
            check_rx_state("rand_rx");
            case ($urandom_range(0, 3))
                0: begin
                    bus_read(REG_DATA, rd);
                    checkOutput("rand_rx_data", rd, {24'h0, m_hold});
                    m_valid = 1'b0;
                end
                1: begin
                    pat = $urandom;
                    bus_write(REG_STATUS, pat);
                    if (pat[3]) m_ovr = 1'b0;
                    if (pat[4]) m_ferr = 1'b0;
                end
                default: ;
            endcase
            check_rx_state("rand_rx_after");
        end

        // Reset in the middle of a transmission.
        mon_en = 1'b0;
        set_div(16'd4);
        applyStimulus(3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_txd", 32'(txd), 32'd1);
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_hold  = 8'h00;
        exp_tx.delete();
        @(negedge clk);
        bus_read(REG_STATUS, rd);
        checkOutput("reset_mid_status", rd, 32'h2);
        bus_read(REG_DIV, rd);
        checkOutput("reset_mid_div", rd, 32'd868);
        bus_read(REG_DATA, rd);
        checkOutput("reset_mid_hold", rd, 32'h0);
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (txd !== 1'b1) low_seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("reset_mid_fifo_empty", 32'(low_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
